// File: rtl/dmem_line_bridge.sv
// Data-cache to word-wide SRAM bridge: line-read bursts for load misses, single-word write-through for stores.
// Optional critical-word-first issue order is enabled by defining DMEM_BRIDGE_CWF_EN.
module dmem_line_bridge #(
  parameter int unsigned WORD       = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SRAM_AW    = 14,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mem_valid,
  input  logic                          mem_for_store,
  input  logic [WORD-1:0]               mem_addr,
  input  logic [WORD-1:0]               mem_wdata,
  output logic                          mem_ready,
  output logic                          mem_last,
  output logic [$clog2(LINE_WORDS)-1:0] mem_beat_idx,
  output logic [WORD-1:0]               mem_rdata,
  output logic                          sram_en,
  output logic                          sram_we,
  output logic [SRAM_AW-1:0]            sram_addr,
  output logic [WORD-1:0]               sram_wdata,
  input  logic [WORD-1:0]               sram_rdata
);

  localparam int unsigned OFFW = $clog2(LINE_WORDS);
  localparam int unsigned LAT  = RD_LATENCY;
  localparam logic [OFFW-1:0] LAST_OFF = OFFW'(LINE_WORDS - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_ISSUE = 3'd1;
  localparam logic [2:0] ST_RD_DRAIN = 3'd2;
  localparam logic [2:0] ST_WR       = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nx;
  logic [OFFW-1:0]    r_iss_cnt;
  logic [OFFW-1:0]    w_iss_cnt_nx;
  logic               r_sram_en;
  logic               w_sram_en_nx;
  logic               r_sram_we;
  logic               w_sram_we_nx;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic [SRAM_AW-1:0] w_sram_addr_nx;
  logic [WORD-1:0]    r_sram_wdata;
  logic [WORD-1:0]    w_sram_wdata_nx;

  // Return pipe: stage LAT-1 is the beat presented to the cache this cycle.
  logic [LAT-1:0]     r_pv;
  logic [LAT-1:0]     r_pl;
  logic [OFFW-1:0]    r_pidx [LAT];

  logic [SRAM_AW-1:0] w_wa;
  logic [OFFW-1:0]    w_first_off;
  logic               w_issue;
  logic               w_wr_beat;
  logic               w_unused;

  assign w_wa      = mem_addr[SRAM_AW+1:2];
  assign w_issue   = (r_state == ST_RD_ISSUE);
  assign w_wr_beat = (r_state == ST_IDLE) && mem_valid && mem_for_store;
  assign w_unused  = ^{mem_addr[WORD-1:SRAM_AW+2], mem_addr[1:0]};

`ifdef DMEM_BRIDGE_CWF_EN
  assign w_first_off = w_wa[OFFW-1:0];
`else
  assign w_first_off = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next state plus next-cycle SRAM command; offsets advance mod LINE_WORDS by natural wrap.
  always_comb begin
    w_state_nx      = r_state;
    w_iss_cnt_nx    = r_iss_cnt;
    w_sram_en_nx    = 1'b0;
    w_sram_we_nx    = 1'b0;
    w_sram_addr_nx  = '0;
    w_sram_wdata_nx = '0;
    case (r_state)
      ST_IDLE: begin
        if (mem_valid) begin
          w_iss_cnt_nx = '0;
          w_sram_en_nx = 1'b1;
          if (mem_for_store) begin
            w_state_nx      = ST_WR;
            w_sram_we_nx    = 1'b1;
            w_sram_addr_nx  = w_wa;
            w_sram_wdata_nx = mem_wdata;
          end else begin
            w_state_nx     = ST_RD_ISSUE;
            w_sram_addr_nx = {w_wa[SRAM_AW-1:OFFW], w_first_off};
          end
        end
      end
      ST_RD_ISSUE: begin
        if (r_iss_cnt == LAST_OFF) begin
          w_state_nx = ST_RD_DRAIN;
        end else begin
          w_iss_cnt_nx   = r_iss_cnt + OFFW'(1);
          w_sram_en_nx   = 1'b1;
          w_sram_addr_nx = {r_sram_addr[SRAM_AW-1:OFFW], r_sram_addr[OFFW-1:0] + OFFW'(1)};
        end
      end
      ST_RD_DRAIN: begin
        if (r_pv[LAT-1] && r_pl[LAT-1]) w_state_nx = ST_DONE;
      end
      ST_WR:   w_state_nx = ST_DONE;
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iss_cnt    <= '0;
      r_sram_en    <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
    end else begin
      r_iss_cnt    <= w_iss_cnt_nx;
      r_sram_en    <= w_sram_en_nx;
      r_sram_we    <= w_sram_we_nx;
      r_sram_addr  <= w_sram_addr_nx;
      r_sram_wdata <= w_sram_wdata_nx;
    end
  end

  // Store beats are injected straight into the output stage, which is empty whenever IDLE accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pv <= '0;
      r_pl <= '0;
      for (int i = 0; i < int'(LAT); i++) r_pidx[i] <= '0;
    end else begin
      r_pv[0]   <= w_issue;
      r_pl[0]   <= w_issue && (r_iss_cnt == LAST_OFF);
      r_pidx[0] <= w_issue ? r_sram_addr[OFFW-1:0] : '0;
      for (int i = 1; i < int'(LAT); i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_pl[i]   <= r_pl[i-1];
        r_pidx[i] <= r_pidx[i-1];
      end
      if (w_wr_beat) begin
        r_pv[LAT-1]   <= 1'b1;
        r_pl[LAT-1]   <= 1'b1;
        r_pidx[LAT-1] <= w_wa[OFFW-1:0];
      end
    end
  end

  assign mem_ready    = r_pv[LAT-1];
  assign mem_last     = r_pl[LAT-1];
  assign mem_beat_idx = r_pidx[LAT-1];
  assign mem_rdata    = (r_pv[LAT-1] && (r_state != ST_WR)) ? sram_rdata : '0;
  assign sram_en      = r_sram_en;
  assign sram_we      = r_sram_we;
  assign sram_addr    = r_sram_addr;
  assign sram_wdata   = r_sram_wdata;

endmodule
